// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: issues one datapath op per go request,
// handshakes with multi-cycle units and commits result/last_result.
module calc_op_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [3:0]  op,
   input  logic [31:0] comb_res,
   input  logic [63:0] mc_res,
   input  logic        mc_done,
   input  logic        mc_err,
   output logic [3:0]  op_sel,
   output logic        mc_start,
   output logic [31:0] shift_src,
   output logic [63:0] result,
   output logic [63:0] last_result,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       op_sel_q, op_sel_d;
   logic [63:0]      result_q, result_d;
   logic [63:0]      last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             settle_q, settle_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             is_mc;
   logic             timeout;

   assign is_mc   = ~op_sel_q[3] & op_sel_q[1];
   assign timeout = (cnt_q == CNT_LAST);

   // EXEC spends its first cycle letting comb_res settle on the new op_sel
   always_comb begin
      state_d  = state_q;
      op_sel_d = op_sel_q;
      result_d = result_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      done_d   = 1'b0;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               op_sel_d = op;
               err_d    = 1'b0;
               settle_d = 1'b1;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (settle_q) begin
               settle_d = 1'b0;
            end else if (is_mc) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               last_d   = result_q;
               result_d = {32'b0, comb_res};
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            if (mc_done) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (mc_err) begin
                  err_d = 1'b1;
               end else begin
                  last_d   = result_q;
                  result_d = (op_sel_q == 4'b0010) ? mc_res
                                                   : {32'b0, mc_res[31:0]};
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_sel_q <= '0;
         result_q <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         settle_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_sel_q <= op_sel_d;
         result_q <= result_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign op_sel      = op_sel_q;
   assign mc_start    = (state_q == S_EXEC) & ~settle_q & is_mc;
   assign shift_src   = result_q[31:0];
   assign result      = result_q;
   assign last_result = last_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: single-cycle, multi-cycle,
// error, timeout, shift chaining, dropped go and mid-WAIT reset.
module tb_calc_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        go;
   logic [3:0]  op;
   logic [31:0] comb_res;
   logic [63:0] mc_res;
   logic        mc_done;
   logic        mc_err;
   logic [3:0]  op_sel;
   logic        mc_start;
   logic [31:0] shift_src;
   logic [63:0] result;
   logic [63:0] last_result;
   logic        busy;
   logic        done;
   logic        err;

   logic [31:0] comb_val;
   logic        lls_mode;
   int          pass_cnt;
   int          total_cnt;

   assign comb_res = lls_mode ? {shift_src[30:0], 1'b0} : comb_val;

   calc_op_sequencer #(.TIMEOUT_CYC(255), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .op(op),
      .comb_res(comb_res), .mc_res(mc_res),
      .mc_done(mc_done), .mc_err(mc_err),
      .op_sel(op_sel), .mc_start(mc_start), .shift_src(shift_src),
      .result(result), .last_result(last_result),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one multi-cycle op; mc_done arrives dly cycles after mc_start
   task automatic run_mc(input logic [3:0] o, input int dly,
                         input logic e, input logic [63:0] r,
                         output int starts, output int got);
      int cd;
      starts = 0;
      got    = 0;
      cd     = 0;
      go = 1'b1;
      op = o;
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         mc_done = 1'b0;
         mc_err  = 1'b0;
         if (done) begin
            got = 1;
            break;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               mc_done = 1'b1;
               mc_err  = e;
               mc_res  = r;
            end
         end
         if (mc_start) begin
            starts++;
            cd = dly;
         end
      end
      mc_done = 1'b0;
   endtask

   task automatic wait_done(output int got);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         go = 1'b0;
         if (done) begin
            got = 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total_cnt++;
      if ({busy, done, err, mc_start} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000",
                  {busy, done, err, mc_start});
      else pass_cnt++;
      total_cnt++;
      if (result !== 64'h0 || last_result !== 64'h0 || op_sel !== 4'h0)
         $display("FAIL reset_regs: got %h/%h/%h want 0/0/0",
                  result, last_result, op_sel);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_addi;
      int bcyc;
      comb_val = 32'h0000_0005;
      go = 1'b1;
      op = 4'b0000;
      @(negedge clk);
      go = 1'b0;
      bcyc = 0;
      if (busy) bcyc++;
      total_cnt++;
      if (done !== 1'b0)
         $display("FAIL addi_early_done: got %b want 0", done);
      else pass_cnt++;
      @(negedge clk);
      if (busy) bcyc++;
      @(negedge clk);
      if (busy) bcyc++;
      total_cnt++;
      if (done !== 1'b1)
         $display("FAIL addi_done_k2: got %b want 1", done);
      else pass_cnt++;
      total_cnt++;
      if (result !== 64'h5 || last_result !== 64'h0)
         $display("FAIL addi_result: got %h/%h want 5/0",
                  result, last_result);
      else pass_cnt++;
      total_cnt++;
      if (bcyc !== 2)
         $display("FAIL addi_busy_cycles: got %0d want 2", bcyc);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0)
         $display("FAIL addi_done_pulse: got %b want 0", done);
      else pass_cnt++;
   endtask

   task automatic test_muli;
      int starts, got;
      run_mc(4'b0010, 3, 1'b0, 64'h0000_0001_FFFF_FFFE, starts, got);
      total_cnt++;
      if (starts !== 1 || got !== 1)
         $display("FAIL muli_handshake: got starts=%0d done=%0d want 1/1",
                  starts, got);
      else pass_cnt++;
      total_cnt++;
      if (result !== 64'h0000_0001_FFFF_FFFE || last_result !== 64'h5)
         $display("FAIL muli_result: got %h/%h want 00000001fffffffe/5",
                  result, last_result);
      else pass_cnt++;
   endtask

   task automatic test_divi_err;
      int starts, got;
      run_mc(4'b0011, 2, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, starts, got);
      total_cnt++;
      if (got !== 1 || err !== 1'b1)
         $display("FAIL divi_err: got done=%0d err=%b want 1/1", got, err);
      else pass_cnt++;
      total_cnt++;
      if (result !== 64'h0000_0001_FFFF_FFFE || last_result !== 64'h5)
         $display("FAIL divi_err_hold: got %h/%h want 00000001fffffffe/5",
                  result, last_result);
      else pass_cnt++;
   endtask

   task automatic test_err_clear;
      int got;
      comb_val = 32'h8000_0001;
      go = 1'b1;
      op = 4'b1000;
      @(negedge clk);
      go = 1'b0;
      total_cnt++;
      if (err !== 1'b0)
         $display("FAIL err_clear: got %b want 0", err);
      else pass_cnt++;
      wait_done(got);
      total_cnt++;
      if (got !== 1 || result !== 64'h8000_0001
          || last_result !== 64'h0000_0001_FFFF_FFFE)
         $display("FAIL and_result: got %h/%h want 80000001/00000001fffffffe",
                  result, last_result);
      else pass_cnt++;
   endtask

   task automatic test_shift;
      int got;
      lls_mode = 1'b1;
      go = 1'b1;
      op = 4'b1100;
      @(negedge clk);
      wait_done(got);
      total_cnt++;
      if (got !== 1 || result !== 64'h2 || last_result !== 64'h8000_0001)
         $display("FAIL lls_chain: got %h/%h want 2/80000001",
                  result, last_result);
      else pass_cnt++;
      total_cnt++;
      if (op_sel !== 4'b1100 || shift_src !== 32'h2)
         $display("FAIL lls_opsel: got %h/%h want c/2", op_sel, shift_src);
      else pass_cnt++;
      lls_mode = 1'b0;
   endtask

   task automatic test_timeout;
      int s_idx, d_idx;
      s_idx = -1;
      d_idx = -1;
      go = 1'b1;
      op = 4'b0110;
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (mc_start && s_idx < 0) s_idx = i;
         if (done) begin
            d_idx = i;
            break;
         end
      end
      total_cnt++;
      if (s_idx < 0 || d_idx < 0 || (d_idx - s_idx) !== 256)
         $display("FAIL timeout_latency: got start=%0d done=%0d want gap 256",
                  s_idx, d_idx);
      else pass_cnt++;
      total_cnt++;
      if (err !== 1'b1 || result !== 64'h2 || last_result !== 64'h8000_0001)
         $display("FAIL timeout_err: got err=%b %h/%h want 1 2/80000001",
                  err, result, last_result);
      else pass_cnt++;
      mc_done = 1'b1;
      mc_res  = 64'hDEAD_0000_BEEF_0000;
      @(negedge clk);
      mc_done = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (result !== 64'h2 || done !== 1'b0 || busy !== 1'b0)
         $display("FAIL late_mc_done: got %h done=%b busy=%b want 2 0 0",
                  result, done, busy);
      else pass_cnt++;
   endtask

   task automatic test_busy_go_and_reset;
      int starts;
      starts = 0;
      go = 1'b1;
      op = 4'b0111;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         go = 1'b1;
         op = 4'b0000;
         @(negedge clk);
         if (mc_start) starts++;
      end
      go = 1'b0;
      total_cnt++;
      if (starts !== 1 || busy !== 1'b1 || op_sel !== 4'b0111)
         $display("FAIL busy_go_dropped: got starts=%0d busy=%b op_sel=%h want 1 1 7",
                  starts, busy, op_sel);
      else pass_cnt++;
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({busy, done, err, mc_start} !== 4'b0000 || result !== 64'h0
          || last_result !== 64'h0 || op_sel !== 4'h0)
         $display("FAIL mid_wait_reset: got %b %h %h %h want 0000 0 0 0",
                  {busy, done, err, mc_start}, result, last_result, op_sel);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b0;
      go        = 1'b0;
      op        = 4'h0;
      comb_val  = 32'h0;
      lls_mode  = 1'b0;
      mc_res    = 64'h0;
      mc_done   = 1'b0;
      mc_err    = 1'b0;
      @(negedge clk);
      test_reset();
      test_addi();
      test_muli();
      test_divi_err();
      test_err_clear();
      test_shift();
      test_timeout();
      test_busy_go_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
